// File: rtl/ex_alu_mdu_pkg.sv
// Shared bus types, operation codes and divider state encodings for the
// MIPS32 execute stage.
package ex_alu_mdu_pkg;

  localparam logic RstEnable = 1'b1;

  typedef logic [7:0]  AluOpBus;
  typedef logic [2:0]  AluSelBus;
  typedef logic [31:0] RegBus;
  typedef logic [4:0]  RegAddrBus;
  typedef logic [63:0] DoubleRegBus;

  // Operation codes
  localparam AluOpBus EXE_NOP_OP   = 8'b0000_0000;
  localparam AluOpBus EXE_AND_OP   = 8'b0010_0100;
  localparam AluOpBus EXE_OR_OP    = 8'b0010_0101;
  localparam AluOpBus EXE_XOR_OP   = 8'b0010_0110;
  localparam AluOpBus EXE_NOR_OP   = 8'b0010_0111;
  localparam AluOpBus EXE_SLL_OP   = 8'b0111_1100;
  localparam AluOpBus EXE_SRL_OP   = 8'b0000_0010;
  localparam AluOpBus EXE_SRA_OP   = 8'b0000_0011;
  localparam AluOpBus EXE_SLT_OP   = 8'b0010_1010;
  localparam AluOpBus EXE_SLTU_OP  = 8'b0010_1011;
  localparam AluOpBus EXE_ADDU_OP  = 8'b0010_0001;
  localparam AluOpBus EXE_SUBU_OP  = 8'b0010_0011;
  localparam AluOpBus EXE_MFHI_OP  = 8'b0001_0000;
  localparam AluOpBus EXE_MTHI_OP  = 8'b0001_0001;
  localparam AluOpBus EXE_MFLO_OP  = 8'b0001_0010;
  localparam AluOpBus EXE_MTLO_OP  = 8'b0001_0011;
  localparam AluOpBus EXE_MULT_OP  = 8'b0001_1000;
  localparam AluOpBus EXE_MULTU_OP = 8'b0001_1001;
  localparam AluOpBus EXE_DIV_OP   = 8'b0001_1010;
  localparam AluOpBus EXE_DIVU_OP  = 8'b0001_1011;

  // Result classes
  localparam AluSelBus EXE_RES_NOP        = 3'b000;
  localparam AluSelBus EXE_RES_LOGIC      = 3'b001;
  localparam AluSelBus EXE_RES_SHIFT      = 3'b010;
  localparam AluSelBus EXE_RES_MOVE       = 3'b011;
  localparam AluSelBus EXE_RES_ARITHMETIC = 3'b100;

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  function automatic logic is_div_op(input AluOpBus op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/ex_alu_mdu_div.sv
// Iterative restoring divider: one quotient bit per cycle on latched
// magnitudes, sign fix-up applied on the final step.
module div_iter
  import ex_alu_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  input  logic               annul,
  output logic [2*WIDTH-1:0] result,
  output logic               ready
);

  localparam int CW = $clog2(WIDTH) + 1;

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             negq_q, negq_d, negr_q, negr_d;

  logic [WIDTH-1:0] abs1, abs2, q_step, r_step;
  logic [WIDTH:0]   shifted, diff;

  // Next-state and datapath for the shift/subtract iteration
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    cnt_d   = cnt_q;
    negq_d  = negq_q;
    negr_d  = negr_q;

    abs1 = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
    abs2 = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;

    // Partial remainder with the next dividend bit brought in; it is always
    // below twice the divisor, so one extra bit is enough for the trial.
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvsr_q};
    if (!diff[WIDTH]) begin
      r_step = diff[WIDTH-1:0];
      q_step = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      r_step = shifted[WIDTH-1:0];
      q_step = {quo_q[WIDTH-2:0], 1'b0};
    end

    case (state_q)
      DIV_IDLE: begin
        if (start) begin
          dvsr_d  = abs2;
          quo_d   = abs1;
          rem_d   = '0;
          cnt_d   = '0;
          negq_d  = signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
          negr_d  = signed_div & opdata1[WIDTH-1];
          state_d = (abs2 == '0) ? DIV_BYZERO : DIV_ON;
        end
      end
      DIV_BYZERO: begin
        quo_d   = '0;
        rem_d   = '0;
        state_d = DIV_END;
      end
      DIV_ON: begin
        quo_d = q_step;
        rem_d = r_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          quo_d   = negq_q ? -q_step : q_step;
          rem_d   = negr_q ? -r_step : r_step;
          state_d = DIV_END;
        end
      end
      default: state_d = DIV_IDLE;
    endcase

    // A flush drops whatever is in flight, including a pending result
    if (annul && state_q != DIV_IDLE) state_d = DIV_IDLE;
  end

  // Divider FSM and operand/result registers
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= DIV_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      cnt_q   <= cnt_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  assign result = {rem_q, quo_q};
  assign ready  = (state_q == DIV_END) && !annul && (rst != RstEnable);

endmodule

// File: rtl/ex_alu_mdu.sv
// MIPS32 execute stage: combinational ALU, single-cycle multiplier and an
// iterative divider that stalls the pipeline while it runs.
module ex_alu_mdu
  import ex_alu_mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  annul_i,
  input  logic [7:0]            aluop_i,
  input  logic [2:0]            alusel_i,
  input  logic [WIDTH-1:0]      reg1_i,
  input  logic [WIDTH-1:0]      reg2_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [WIDTH-1:0]      hi_i,
  input  logic [WIDTH-1:0]      lo_i,
  output logic [WIDTH-1:0]      wdata_o,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic                  whilo_o,
  output logic [WIDTH-1:0]      hi_o,
  output logic [WIDTH-1:0]      lo_o,
  output logic                  stallreq_o
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0]   logic_res, shift_res, arith_res, move_res;
  logic [2*WIDTH-1:0] mul_a, mul_b, mul_res, div_res;
  logic [SHW-1:0]     sh;
  logic               mul_signed, div_ready, div_start;

  assign sh = reg1_i[SHW-1:0];

  // Logic, shift, arithmetic/compare and HI/LO read results
  always_comb begin
    logic_res = '0;
    shift_res = '0;
    arith_res = '0;
    move_res  = '0;
    case (aluop_i)
      EXE_OR_OP:   logic_res = reg1_i | reg2_i;
      EXE_AND_OP:  logic_res = reg1_i & reg2_i;
      EXE_XOR_OP:  logic_res = reg1_i ^ reg2_i;
      EXE_NOR_OP:  logic_res = ~(reg1_i | reg2_i);
      EXE_SLL_OP:  shift_res = reg2_i << sh;
      EXE_SRL_OP:  shift_res = reg2_i >> sh;
      EXE_SRA_OP:  shift_res = WIDTH'($signed(reg2_i) >>> sh);
      EXE_ADDU_OP: arith_res = reg1_i + reg2_i;
      EXE_SUBU_OP: arith_res = reg1_i - reg2_i;
      EXE_SLT_OP:  arith_res = WIDTH'($signed(reg1_i) < $signed(reg2_i));
      EXE_SLTU_OP: arith_res = WIDTH'(reg1_i < reg2_i);
      EXE_MFHI_OP: move_res  = hi_i;
      EXE_MFLO_OP: move_res  = lo_i;
      default: ;
    endcase
  end

  // One 2W-bit multiplier serves both MULT and MULTU; only the operand
  // extension differs, and the low 2W bits are exact for either.
  assign mul_signed = (aluop_i == EXE_MULT_OP);
  assign mul_a      = {{WIDTH{mul_signed & reg1_i[WIDTH-1]}}, reg1_i};
  assign mul_b      = {{WIDTH{mul_signed & reg2_i[WIDTH-1]}}, reg2_i};
  assign mul_res    = mul_a * mul_b;

  assign div_start = is_div_op(aluop_i) & ~div_ready & ~annul_i;

  div_iter #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .rst        (rst),
    .start      (div_start),
    .signed_div (aluop_i == EXE_DIV_OP),
    .opdata1    (reg1_i),
    .opdata2    (reg2_i),
    .annul      (annul_i),
    .result     (div_res),
    .ready      (div_ready)
  );

  // Result select, HI/LO write and stall, all forced low during reset
  always_comb begin
    wdata_o    = '0;
    wd_o       = '0;
    wreg_o     = 1'b0;
    whilo_o    = 1'b0;
    hi_o       = '0;
    lo_o       = '0;
    stallreq_o = 1'b0;
    if (rst != RstEnable) begin
      wd_o       = wd_i;
      wreg_o     = wreg_i;
      stallreq_o = div_start;
      case (alusel_i)
        EXE_RES_LOGIC:      wdata_o = logic_res;
        EXE_RES_SHIFT:      wdata_o = shift_res;
        EXE_RES_ARITHMETIC: wdata_o = arith_res;
        EXE_RES_MOVE:       wdata_o = move_res;
        default:            wdata_o = '0;
      endcase
      case (aluop_i)
        EXE_MTHI_OP: begin
          whilo_o = 1'b1;
          hi_o    = reg1_i;
          lo_o    = lo_i;
        end
        EXE_MTLO_OP: begin
          whilo_o = 1'b1;
          hi_o    = hi_i;
          lo_o    = reg1_i;
        end
        EXE_MULT_OP, EXE_MULTU_OP: begin
          whilo_o = 1'b1;
          hi_o    = mul_res[2*WIDTH-1:WIDTH];
          lo_o    = mul_res[WIDTH-1:0];
        end
        EXE_DIV_OP, EXE_DIVU_OP: begin
          if (div_ready) begin
            whilo_o = 1'b1;
            hi_o    = div_res[2*WIDTH-1:WIDTH];
            lo_o    = div_res[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_alu_mdu.sv
// Scoreboard bench for ex_alu_mdu: the driver queues the expected outputs
// for each cycle it drives; the monitor compares them mid-cycle.
module tb_ex_alu_mdu;
  import ex_alu_mdu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1, annul_i = 1'b0, wreg_i = 1'b0;
  logic [7:0]   aluop_i = '0;
  logic [2:0]   alusel_i = '0;
  logic [W-1:0] reg1_i = '0, reg2_i = '0;
  logic [W-1:0] hi_i = 32'h1111_2222, lo_i = 32'h3333_4444;
  logic [4:0]   wd_i = '0;
  logic [W-1:0] wdata_o, hi_o, lo_o;
  logic [4:0]   wd_o;
  logic         wreg_o, whilo_o, stallreq_o;

  ex_alu_mdu #(.WIDTH(W), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .annul_i(annul_i), .aluop_i(aluop_i),
    .alusel_i(alusel_i), .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i),
    .wreg_i(wreg_i), .hi_i(hi_i), .lo_i(lo_i), .wdata_o(wdata_o),
    .wd_o(wd_o), .wreg_o(wreg_o), .whilo_o(whilo_o), .hi_o(hi_o),
    .lo_o(lo_o), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] wdata;
    logic [4:0]   wd;
    logic         wreg;
    logic         whilo;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         stall;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0, failures = 0;

  function automatic exp_t ex(input logic [W-1:0] wdata, input logic [4:0] wd,
                              input logic wreg, input logic whilo,
                              input logic [W-1:0] hi, input logic [W-1:0] lo,
                              input logic stall);
    exp_t e;
    e.wdata = wdata; e.wd = wd; e.wreg = wreg; e.whilo = whilo;
    e.hi = hi; e.lo = lo; e.stall = stall;
    return e;
  endfunction

  // Drive one cycle of inputs just after the edge and queue its expectation
  task automatic drive(input logic r, input logic an, input logic [7:0] op,
                       input logic [2:0] sel, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [4:0] wd,
                       input logic wr, input exp_t e, input string nm);
    @(posedge clk);
    #1;
    rst = r; annul_i = an; aluop_i = op; alusel_i = sel;
    reg1_i = a; reg2_i = b; wd_i = wd; wreg_i = wr;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // A divide held in EX: stall_cycles of stall, then one result cycle.
  // With junk set, operands are scrambled after the start cycle.
  task automatic run_div(input logic [7:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] q,
                         input logic [W-1:0] r, input int stall_cycles,
                         input bit junk, input string nm);
    logic [W-1:0] ja, jb;
    for (int i = 0; i < stall_cycles; i++) begin
      ja = (junk && i > 0) ? 32'hDEAD_BEEF : a;
      jb = (junk && i > 0) ? 32'h0000_0003 : b;
      drive(0, 0, op, EXE_RES_NOP, ja, jb, 5'd0, 1'b0,
            ex('0, 5'd0, 1'b0, 1'b0, '0, '0, 1'b1), {nm, "_stall"});
    end
    ja = junk ? 32'hDEAD_BEEF : a;
    jb = junk ? 32'h0000_0003 : b;
    drive(0, 0, op, EXE_RES_NOP, ja, jb, 5'd0, 1'b0,
          ex('0, 5'd0, 1'b0, 1'b1, r, q, 1'b0), {nm, "_result"});
  endtask

  task automatic nop(input string nm);
    drive(0, 0, EXE_NOP_OP, EXE_RES_NOP, '0, '0, 5'd0, 1'b0,
          ex('0, 5'd0, 1'b0, 1'b0, '0, '0, 1'b0), nm);
  endtask

  // Monitor: compare the queued expectation against the outputs mid-cycle
  always @(negedge clk) begin
    exp_t  e, g;
    string nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      g  = ex(wdata_o, wd_o, wreg_o, whilo_o, hi_o, lo_o, stallreq_o);
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL %s: got wdata=%h wd=%0d wreg=%b whilo=%b hi=%h lo=%h stall=%b; want wdata=%h wd=%0d wreg=%b whilo=%b hi=%h lo=%h stall=%b",
                 nm, g.wdata, g.wd, g.wreg, g.whilo, g.hi, g.lo, g.stall,
                 e.wdata, e.wd, e.wreg, e.whilo, e.hi, e.lo, e.stall);
      end
    end
  end

  initial begin
    // Reset holds every output low even with a live op on the inputs
    drive(1, 0, EXE_OR_OP, EXE_RES_LOGIC, 32'h1100, 32'h0101, 5'd3, 1'b1,
          ex('0, 5'd0, 1'b0, 1'b0, '0, '0, 1'b0), "reset0");
    drive(1, 0, EXE_DIV_OP, EXE_RES_NOP, 32'd7, 32'd2, 5'd3, 1'b1,
          ex('0, 5'd0, 1'b0, 1'b0, '0, '0, 1'b0), "reset1");

    // Logic, shift, arithmetic, compare
    drive(0, 0, EXE_OR_OP, EXE_RES_LOGIC, 32'h0000_1100, 32'h0000_0101, 5'd3, 1'b1,
          ex(32'h0000_1101, 5'd3, 1'b1, 1'b0, '0, '0, 1'b0), "or");
    drive(0, 0, EXE_AND_OP, EXE_RES_LOGIC, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd4, 1'b1,
          ex(32'h00F0_1234, 5'd4, 1'b1, 1'b0, '0, '0, 1'b0), "and");
    drive(0, 0, EXE_XOR_OP, EXE_RES_LOGIC, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd5, 1'b1,
          ex(32'hF0F0_0F0F, 5'd5, 1'b1, 1'b0, '0, '0, 1'b0), "xor");
    drive(0, 0, EXE_NOR_OP, EXE_RES_LOGIC, 32'h0000_FFFF, 32'h00FF_0000, 5'd6, 1'b1,
          ex(32'hFF00_0000, 5'd6, 1'b1, 1'b0, '0, '0, 1'b0), "nor");
    drive(0, 0, EXE_SRA_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0010, 5'd7, 1'b1,
          ex(32'hF800_0001, 5'd7, 1'b1, 1'b0, '0, '0, 1'b0), "sra");
    drive(0, 0, EXE_SRL_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0010, 5'd7, 1'b1,
          ex(32'h0800_0001, 5'd7, 1'b1, 1'b0, '0, '0, 1'b0), "srl");
    drive(0, 0, EXE_SLL_OP, EXE_RES_SHIFT, 32'd8, 32'h1234_5678, 5'd8, 1'b1,
          ex(32'h3456_7800, 5'd8, 1'b1, 1'b0, '0, '0, 1'b0), "sll");
    drive(0, 0, EXE_SLTU_OP, EXE_RES_ARITHMETIC, 32'd1, 32'hFFFF_FFFF, 5'd9, 1'b1,
          ex(32'd1, 5'd9, 1'b1, 1'b0, '0, '0, 1'b0), "sltu");
    drive(0, 0, EXE_SLT_OP, EXE_RES_ARITHMETIC, 32'd1, 32'hFFFF_FFFF, 5'd9, 1'b1,
          ex(32'd0, 5'd9, 1'b1, 1'b0, '0, '0, 1'b0), "slt_pos_neg");
    drive(0, 0, EXE_SLT_OP, EXE_RES_ARITHMETIC, 32'hFFFF_FFFF, 32'd1, 5'd9, 1'b1,
          ex(32'd1, 5'd9, 1'b1, 1'b0, '0, '0, 1'b0), "slt_neg_pos");
    drive(0, 0, EXE_ADDU_OP, EXE_RES_ARITHMETIC, 32'hFFFF_FFFF, 32'd2, 5'd10, 1'b1,
          ex(32'd1, 5'd10, 1'b1, 1'b0, '0, '0, 1'b0), "addu_wrap");
    drive(0, 0, EXE_SUBU_OP, EXE_RES_ARITHMETIC, 32'd0, 32'd1, 5'd11, 1'b1,
          ex(32'hFFFF_FFFF, 5'd11, 1'b1, 1'b0, '0, '0, 1'b0), "subu_wrap");
    drive(0, 0, EXE_OR_OP, EXE_RES_NOP, 32'h0000_1100, 32'h0000_0101, 5'd12, 1'b1,
          ex('0, 5'd12, 1'b1, 1'b0, '0, '0, 1'b0), "sel_none");
    drive(0, 0, 8'hFF, EXE_RES_LOGIC, 32'h1234_5678, 32'h9ABC_DEF0, 5'd13, 1'b1,
          ex('0, 5'd13, 1'b1, 1'b0, '0, '0, 1'b0), "unknown_op");

    // HI/LO moves
    drive(0, 0, EXE_MFHI_OP, EXE_RES_MOVE, '0, '0, 5'd14, 1'b1,
          ex(32'h1111_2222, 5'd14, 1'b1, 1'b0, '0, '0, 1'b0), "mfhi");
    drive(0, 0, EXE_MFLO_OP, EXE_RES_MOVE, '0, '0, 5'd15, 1'b1,
          ex(32'h3333_4444, 5'd15, 1'b1, 1'b0, '0, '0, 1'b0), "mflo");
    drive(0, 0, EXE_MTHI_OP, EXE_RES_NOP, 32'hAAAA_5555, '0, 5'd0, 1'b0,
          ex('0, 5'd0, 1'b0, 1'b1, 32'hAAAA_5555, 32'h3333_4444, 1'b0), "mthi");
    drive(0, 0, EXE_MTLO_OP, EXE_RES_NOP, 32'h0000_5A5A, '0, 5'd0, 1'b0,
          ex('0, 5'd0, 1'b0, 1'b1, 32'h1111_2222, 32'h0000_5A5A, 1'b0), "mtlo");

    // Multiply: -7 * 3
    drive(0, 0, EXE_MULT_OP, EXE_RES_NOP, 32'hFFFF_FFF9, 32'd3, 5'd0, 1'b0,
          ex('0, 5'd0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0), "mult");
    drive(0, 0, EXE_MULTU_OP, EXE_RES_NOP, 32'hFFFF_FFF9, 32'd3, 5'd0, 1'b0,
          ex('0, 5'd0, 1'b0, 1'b1, 32'h0000_0002, 32'hFFFF_FFEB, 1'b0), "multu");

    // Divides: -7/2 signed, divide-by-zero then back-to-back 100/7 with
    // operands scrambled in flight, and the signed overflow corner
    run_div(EXE_DIV_OP,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 0, "div_m7_2");
    nop("after_div");
    run_div(EXE_DIVU_OP, 32'd55, 32'd0, 32'd0, 32'd0, 2, 0, "divu_by0");
    run_div(EXE_DIVU_OP, 32'd100, 32'd7, 32'd14, 32'd2, 33, 1, "divu_100_7");
    run_div(EXE_DIV_OP,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33, 0, "div_min_m1");
    nop("after_min");

    // Flush at cycle 10 of a divide: no stall that cycle, no result pulse
    // later, and a fresh divide afterwards takes the full latency
    for (int i = 0; i < 10; i++)
      drive(0, 0, EXE_DIV_OP, EXE_RES_NOP, 32'd100, 32'd7, 5'd0, 1'b0,
            ex('0, 5'd0, 1'b0, 1'b0, '0, '0, 1'b1), "annul_pre");
    drive(0, 1, EXE_DIV_OP, EXE_RES_NOP, 32'd100, 32'd7, 5'd0, 1'b0,
          ex('0, 5'd0, 1'b0, 1'b0, '0, '0, 1'b0), "annul_cycle");
    nop("annul_idle");
    run_div(EXE_DIVU_OP, 32'd50, 32'd5, 32'd10, 32'd0, 33, 0, "div_after_annul");

    // Reset in the middle of a divide
    for (int i = 0; i < 5; i++)
      drive(0, 0, EXE_DIV_OP, EXE_RES_NOP, 32'hFFFF_FFF9, 32'd2, 5'd0, 1'b0,
            ex('0, 5'd0, 1'b0, 1'b0, '0, '0, 1'b1), "rst_pre");
    drive(1, 0, EXE_DIV_OP, EXE_RES_NOP, 32'hFFFF_FFF9, 32'd2, 5'd9, 1'b1,
          ex('0, 5'd0, 1'b0, 1'b0, '0, '0, 1'b0), "rst_mid_div");
    run_div(EXE_DIVU_OP, 32'd9, 32'd4, 32'd2, 32'd1, 33, 0, "div_after_rst");
    nop("final_nop");

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
